alien_fleet_controller: RTL and testbench

// Sequences the alien formation: owns the fleet origin, the march direction and the alive mask.

---
 rtl/alien_fleet_controller_if.sv | 64 ++++++
 rtl/alien_fleet_controller.sv | 263 ++++++++++++++++++++++++++
 tb/tb_alien_fleet_controller.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/alien_fleet_controller_if.sv
// ============================================================================
// Module      : alien_fleet_controller_if
// Description : Bundle between the game FSM / collision logic and the alien
//               fleet controller. It carries the wave-start and kill-event
//               inputs, plus the formation state driven towards the enemy
//               sprite array.
//   master : game side. Drives start/kill_*, reads the fleet state.
//   slave  : alien_fleet_controller. Reads start/kill_*, drives the fleet state.
//   Signals:
//     start             wave load / launch request
//     kill_valid        one alien destroyed this cycle
//     kill_col/kill_row coordinates of the destroyed alien
//     fleet_x/fleet_y   formation origin (top-left of col 0, row 0)
//     enemy_direction_X 0 = left, 1 = right
//     enemy_direction_Y high for the single cycle a drop commits
//     step_pulse        high for the cycle any step commits
//     alive_mask        bit r*COLS+c = alien alive
//     alive_count       population of alive_mask
//     wave_cleared      level, formation destroyed
//     fleet_landed      level, formation reached the landing line
//     wave_num          waves loaded, saturating at 15
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface alien_fleet_controller_if #(
    parameter int COLS = 8,
    parameter int ROWS = 4
);
    localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CNT_W = $clog2(COLS * ROWS + 1);

    logic                   start;
    logic                   kill_valid;
    logic [COL_W-1:0]       kill_col;
    logic [ROW_W-1:0]       kill_row;
    logic [9:0]             fleet_x;
    logic [9:0]             fleet_y;
    logic                   enemy_direction_X;
    logic                   enemy_direction_Y;
    logic                   step_pulse;
    logic [COLS*ROWS-1:0]   alive_mask;
    logic [CNT_W-1:0]       alive_count;
    logic                   wave_cleared;
    logic                   fleet_landed;
    logic [3:0]             wave_num;

    modport master (
        output start, kill_valid, kill_col, kill_row,
        input  fleet_x, fleet_y, enemy_direction_X, enemy_direction_Y,
               step_pulse, alive_mask, alive_count, wave_cleared,
               fleet_landed, wave_num
    );

    modport slave (
        input  start, kill_valid, kill_col, kill_row,
        output fleet_x, fleet_y, enemy_direction_X, enemy_direction_Y,
               step_pulse, alive_mask, alive_count, wave_cleared,
               fleet_landed, wave_num
    );
endinterface

`default_nettype wire

// File: rtl/alien_fleet_controller.sv
// ============================================================================
// Module      : alien_fleet_controller
// Description : Sequences the alien formation. Owns the fleet origin, the
//               march direction and the alive mask. Marches the formation
//               sideways once per period. At a screen edge it drops the
//               formation and reverses. It ends the wave on a full kill
//               (CLEARED) or on touchdown (LANDED).
// Ports       :
//   frame_clk  frame-rate clock
//   Reset      synchronous, active-high
//   bus        alien_fleet_controller_if.slave (start, kills, fleet state)
// Config      : FLEET_SPEEDUP_EN - when defined, the march period shrinks with
//               the population:
//               max(MIN_PERIOD, min(BASE_PERIOD, alive_count + MIN_PERIOD)).
//               A new period takes effect at the next counter wrap.
//               When undefined, the period is fixed at BASE_PERIOD.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alien_fleet_controller #(
    parameter int COLS        = 8,
    parameter int ROWS        = 4,
    parameter int ALIEN_W     = 50,
    parameter int ALIEN_H     = 44,
    parameter int COL_PITCH   = 60,
    parameter int ROW_PITCH   = 50,
    parameter int START_X     = 40,
    parameter int START_Y     = 40,
    parameter int SCREEN_L    = 0,
    parameter int SCREEN_R    = 639,
    parameter int LANDING_Y   = 400,
    parameter int STEP_X      = 4,
    parameter int STEP_Y      = 16,
    parameter int BASE_PERIOD = 30,
    parameter int MIN_PERIOD  = 2
) (
    input  wire logic               frame_clk,
    input  wire logic               Reset,
    alien_fleet_controller_if.slave bus
);
    localparam int N       = COLS * ROWS;
    localparam int COL_W   = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int ROW_W   = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CNT_W   = $clog2(N + 1);
    // The frame counter must be able to hold either period bound.
    localparam int PER_MAX = (BASE_PERIOD > MIN_PERIOD) ? BASE_PERIOD : MIN_PERIOD;
    localparam int PER_W   = $clog2(PER_MAX + 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_MARCH   = 3'd1;
    localparam logic [2:0] S_DROP    = 3'd2;
    localparam logic [2:0] S_CLEARED = 3'd3;
    localparam logic [2:0] S_LANDED  = 3'd4;

    localparam logic [9:0]       c_START_X     = 10'(START_X);
    localparam logic [9:0]       c_START_Y     = 10'(START_Y);
    localparam logic [9:0]       c_STEP_X      = 10'(STEP_X);
    localparam logic [9:0]       c_STEP_Y      = 10'(STEP_Y);
    localparam logic [10:0]      c_COL_PITCH   = 11'(COL_PITCH);
    localparam logic [10:0]      c_ROW_PITCH   = 11'(ROW_PITCH);
    localparam logic [10:0]      c_W_M1        = 11'(ALIEN_W - 1);
    localparam logic [10:0]      c_H_M1        = 11'(ALIEN_H - 1);
    localparam logic [10:0]      c_STEP_X11    = 11'(STEP_X);
    localparam logic [10:0]      c_STEP_Y11    = 11'(STEP_Y);
    localparam logic [10:0]      c_SCREEN_R    = 11'(SCREEN_R);
    localparam logic [10:0]      c_LEFT_LIMIT  = 11'(SCREEN_L + STEP_X);
    localparam logic [10:0]      c_LANDING_Y   = 11'(LANDING_Y);
    localparam logic [PER_W-1:0] c_PER_ONE     = PER_W'(1);
    localparam logic [CNT_W-1:0] c_CNT_ONE     = CNT_W'(1);

    logic [2:0]       r_state;
    logic [9:0]       r_fleet_x;
    logic [9:0]       r_fleet_y;
    logic             r_dir_x;
    logic             r_dir_y;
    logic             r_step_pulse;
    logic [N-1:0]     r_mask;
    logic [3:0]       r_wave_num;
    logic [PER_W-1:0] r_counter;

    logic [COLS-1:0]  w_col_any;
    logic [ROWS-1:0]  w_row_any;
    logic [COL_W-1:0] w_lc;
    logic [COL_W-1:0] w_rc;
    logic [ROW_W-1:0] w_br;
    logic [10:0]      w_left;
    logic [10:0]      w_right;
    logic [10:0]      w_drop_bottom;
    logic             w_edge_hit;
    logic             w_kill_en;
    logic [N-1:0]     w_kill_bit;
    logic [N-1:0]     w_mask_after;
    logic [CNT_W-1:0] w_alive_count;
    logic [PER_W-1:0] w_period;
    logic             w_step_due;
    logic             w_load;

    assign w_load    = bus.start && ((r_state == S_IDLE) || (r_state == S_CLEARED));
    assign w_kill_en = bus.kill_valid && ((r_state == S_MARCH) || (r_state == S_DROP));

    // Formation extents come from the registered mask, so a kill that
    // lands on the same edge as a step cannot change that step's decision.
    always_comb begin
        w_col_any = '0;
        w_row_any = '0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                if (r_mask[r*COLS + c]) begin
                    w_col_any[c] = 1'b1;
                    w_row_any[r] = 1'b1;
                end
            end
        end
        w_lc = '0;
        for (int c = COLS - 1; c >= 0; c--) begin
            if (w_col_any[c]) w_lc = COL_W'(c);
        end
        w_rc = '0;
        for (int c = 0; c < COLS; c++) begin
            if (w_col_any[c]) w_rc = COL_W'(c);
        end
        w_br = '0;
        for (int r = 0; r < ROWS; r++) begin
            if (w_row_any[r]) w_br = ROW_W'(r);
        end
    end

    assign w_left        = {1'b0, r_fleet_x} + 11'(w_lc) * c_COL_PITCH;
    assign w_right       = {1'b0, r_fleet_x} + 11'(w_rc) * c_COL_PITCH + c_W_M1;
    // Bottom edge as it will be once the pending drop has committed.
    assign w_drop_bottom = {1'b0, r_fleet_y} + c_STEP_Y11 + 11'(w_br) * c_ROW_PITCH + c_H_M1;
    assign w_edge_hit    = r_dir_x ? ((w_right + c_STEP_X11) > c_SCREEN_R)
                                   : (w_left < c_LEFT_LIMIT);

    // Out-of-range coordinates are dropped rather than aliased onto another alien.
    always_comb begin
        w_kill_bit = '0;
        for (int i = 0; i < N; i++) begin
            if (w_kill_en && (int'(bus.kill_col) < COLS) && (int'(bus.kill_row) < ROWS) &&
                (i == int'(bus.kill_row) * COLS + int'(bus.kill_col))) begin
                w_kill_bit[i] = 1'b1;
            end
        end
    end

    assign w_mask_after = r_mask & ~w_kill_bit;

    always_comb begin
        w_alive_count = '0;
        for (int i = 0; i < N; i++) begin
            if (r_mask[i]) w_alive_count = w_alive_count + c_CNT_ONE;
        end
    end

`ifdef FLEET_SPEEDUP_EN
    logic [PER_W-1:0] r_period;

    function automatic logic [PER_W-1:0] f_period(input logic [CNT_W-1:0] n);
        int p;
        p = int'(n) + MIN_PERIOD;
        if (p > BASE_PERIOD) p = BASE_PERIOD;
        if (p < MIN_PERIOD)  p = MIN_PERIOD;
        return PER_W'(p);
    endfunction

    // The period is latched only when the counter is at zero (wave load or
    // wrap). A shrinking period can then never strand the counter past
    // its terminal count.
    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            r_period <= PER_W'(BASE_PERIOD);
        end else if (w_load) begin
            r_period <= f_period(CNT_W'(N));
        end else if (w_step_due) begin
            r_period <= f_period(w_alive_count);
        end
    end

    assign w_period = r_period;
`else
    assign w_period = PER_W'(BASE_PERIOD);
`endif

    assign w_step_due = (r_state == S_MARCH) && (r_counter == (w_period - c_PER_ONE));

    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            r_state      <= S_IDLE;
            r_fleet_x    <= c_START_X;
            r_fleet_y    <= c_START_Y;
            r_dir_x      <= 1'b1;
            r_dir_y      <= 1'b0;
            r_step_pulse <= 1'b0;
            r_mask       <= '0;
            r_wave_num   <= 4'd0;
            r_counter    <= '0;
        end else begin
            r_step_pulse <= 1'b0;
            r_dir_y      <= 1'b0;
            r_mask       <= w_mask_after;
            case (r_state)
                S_IDLE, S_CLEARED: begin
                    if (bus.start) begin
                        r_state   <= S_MARCH;
                        r_mask    <= '1;
                        r_fleet_x <= c_START_X;
                        r_fleet_y <= c_START_Y;
                        r_dir_x   <= 1'b1;
                        r_counter <= '0;
                        if (r_wave_num != 4'hF) r_wave_num <= r_wave_num + 4'd1;
                    end
                end
                S_MARCH: begin
                    // Losing the last alien ends the wave and freezes the origin.
                    if (w_mask_after == '0) begin
                        r_state <= S_CLEARED;
                    end else if (w_step_due) begin
                        r_counter <= '0;
                        if (w_edge_hit) begin
                            r_state <= S_DROP;
                        end else begin
                            r_fleet_x    <= r_dir_x ? (r_fleet_x + c_STEP_X) : (r_fleet_x - c_STEP_X);
                            r_step_pulse <= 1'b1;
                        end
                    end else begin
                        r_counter <= r_counter + c_PER_ONE;
                    end
                end
                S_DROP: begin
                    if (w_mask_after == '0) begin
                        r_state <= S_CLEARED;
                    end else begin
                        r_fleet_y    <= r_fleet_y + c_STEP_Y;
                        r_dir_x      <= ~r_dir_x;
                        r_dir_y      <= 1'b1;
                        r_step_pulse <= 1'b1;
                        r_state      <= (w_drop_bottom >= c_LANDING_Y) ? S_LANDED : S_MARCH;
                    end
                end
                S_LANDED: begin
                    r_state <= S_LANDED;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.fleet_x           = r_fleet_x;
    assign bus.fleet_y           = r_fleet_y;
    assign bus.enemy_direction_X = r_dir_x;
    assign bus.enemy_direction_Y = r_dir_y;
    assign bus.step_pulse        = r_step_pulse;
    assign bus.alive_mask        = r_mask;
    assign bus.alive_count       = w_alive_count;
    assign bus.wave_cleared      = (r_state == S_CLEARED);
    assign bus.fleet_landed      = (r_state == S_LANDED);
    assign bus.wave_num          = r_wave_num;
endmodule

`default_nettype wire

// File: tb/tb_alien_fleet_controller.sv
// ============================================================================
// Module      : tb_alien_fleet_controller
// Description : Scoreboard bench for alien_fleet_controller. The stimulus
//               pushes every expected step/drop (cycle, origin, direction)
//               into a queue. A monitor pops one entry per step_pulse and
//               compares. Wave-level state is checked directly against
//               hand-computed values.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alien_fleet_controller;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alien_fleet_controller_if #(.COLS(8), .ROWS(4)) bus ();

    alien_fleet_controller dut (
        .frame_clk (clk),
        .Reset     (rst),
        .bus       (bus)
    );

    typedef struct {
        logic [31:0] cyc;
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] dx;
        logic [31:0] dy;
    } exp_t;

    exp_t sb[$];
    exp_t e_mon;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    logic mon_en = 1'b0;
    int   s;
    int   n;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d (0x%0h) expected=%0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    // Monitor: every committed step must match the next scoreboard entry.
    always @(negedge clk) begin
        if (mon_en && bus.step_pulse) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL step_unexpected actual=step at cycle %0d x=%0d expected=no step",
                         cyc, bus.fleet_x);
            end else begin
                e_mon = sb.pop_front();
                chk("step_cycle", 32'(cyc), e_mon.cyc);
                chk("step_x",     32'(bus.fleet_x), e_mon.x);
                chk("step_y",     32'(bus.fleet_y), e_mon.y);
                chk("step_dir_x", 32'(bus.enemy_direction_X), e_mon.dx);
                chk("step_dir_y", 32'(bus.enemy_direction_Y), e_mon.dy);
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic kill(input int col, input int row);
        bus.kill_valid = 1'b1;
        bus.kill_col   = 3'(col);
        bus.kill_row   = 2'(row);
        tick();
        bus.kill_valid = 1'b0;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) tick();
    endtask

    task automatic push(input int c, input int x, input int y, input int dx, input int dy);
        exp_t e;
        e.cyc = 32'(c);
        e.x   = 32'(x);
        e.y   = 32'(y);
        e.dx  = 32'(dx);
        e.dy  = 32'(dy);
        sb.push_back(e);
    endtask

    task automatic check_reset();
        chk("rst_fleet_x",  32'(bus.fleet_x), 32'd40);
        chk("rst_fleet_y",  32'(bus.fleet_y), 32'd40);
        chk("rst_dir_x",    32'(bus.enemy_direction_X), 32'd1);
        chk("rst_dir_y",    32'(bus.enemy_direction_Y), 32'd0);
        chk("rst_mask",     32'(bus.alive_mask), 32'h0);
        chk("rst_count",    32'(bus.alive_count), 32'd0);
        chk("rst_step",     32'(bus.step_pulse), 32'd0);
        chk("rst_cleared",  32'(bus.wave_cleared), 32'd0);
        chk("rst_landed",   32'(bus.fleet_landed), 32'd0);
        chk("rst_wave_num", 32'(bus.wave_num), 32'd0);
    endtask

    initial begin
        rst            = 1'b1;
        bus.start      = 1'b0;
        bus.kill_valid = 1'b0;
        bus.kill_col   = 3'd0;
        bus.kill_row   = 2'd0;
        repeat (3) tick();
        rst = 1'b0;
        check_reset();

        // Kills are ignored while idle.
        kill(0, 0);
        chk("idle_kill_mask", 32'(bus.alive_mask), 32'h0);

        // Wave 1 load.
        pulse_start();
        s = cyc;
        chk("w1_mask",     32'(bus.alive_mask), 32'hFFFF_FFFF);
        chk("w1_count",    32'(bus.alive_count), 32'd32);
        chk("w1_wave_num", 32'(bus.wave_num), 32'd1);
        chk("w1_fleet_x",  32'(bus.fleet_x), 32'd40);
        chk("w1_dir_x",    32'(bus.enemy_direction_X), 32'd1);
        chk("w1_cleared",  32'(bus.wave_cleared), 32'd0);

        // A repeated kill of the same alien only counts once.
        kill(0, 0);
        chk("kill1_count", 32'(bus.alive_count), 32'd31);
        kill(0, 0);
        chk("kill2_count", 32'(bus.alive_count), 32'd31);
        chk("kill2_mask",  32'(bus.alive_mask), 32'hFFFF_FFFE);
        kill(7, 0);
        kill(7, 1);
        kill(7, 2);
        chk("col7_count", 32'(bus.alive_count), 32'd28);
        chk("col7_mask",  32'(bus.alive_mask), 32'hFF7F_7F7E);
        pulse_start();
        chk("start_in_march_wave_num", 32'(bus.wave_num), 32'd1);

        // Col 7 row 3 keeps rc=7: 32 marches to x=168, then a drop.
        for (int k = 1; k <= 32; k++) push(s + 30 * k, 40 + 4 * k, 40, 1, 0);
        push(s + 991, 168, 56, 0, 1);
        mon_en = 1'b1;
        // The last col-7 alien dies on the edge where step 33 is due.
        // The drop still uses the mask from before that kill.
        wait_until(s + 989);
        kill(7, 3);
        wait_until(s + 992);
        chk("drop_dir_y_one_cycle", 32'(bus.enemy_direction_Y), 32'd0);
        chk("drop_step_clear",      32'(bus.step_pulse), 32'd0);
        chk("drop_fleet_y",         32'(bus.fleet_y), 32'd56);
        chk("drop_dir_x",           32'(bus.enemy_direction_X), 32'd0);
        chk("coincident_kill_count", 32'(bus.alive_count), 32'd27);
        chk("w1_sb_drained",        32'(sb.size()), 32'd0);
        mon_en = 1'b0;
        sb.delete();

        // Let the fleet descend. br=3 gives bottom = y+193, which first
        // reaches 400 at y=216.
        n = 0;
        while (!bus.fleet_landed && n < 40000) begin
            tick();
            n++;
        end
        chk("landed",        32'(bus.fleet_landed), 32'd1);
        chk("landed_fleet_y", 32'(bus.fleet_y), 32'd216);
        pulse_start();
        chk("landed_start_wave_num", 32'(bus.wave_num), 32'd1);
        chk("landed_stays",          32'(bus.fleet_landed), 32'd1);
        kill(1, 0);
        chk("landed_kill_count", 32'(bus.alive_count), 32'd27);

        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset();

        // Wave with column 7 fully dead: rc=6, 47 marches to x=228, then a drop.
        pulse_start();
        s = cyc;
        chk("w2_wave_num", 32'(bus.wave_num), 32'd1);
        for (int r = 0; r < 4; r++) kill(7, r);
        chk("w2_count", 32'(bus.alive_count), 32'd28);
        chk("w2_mask",  32'(bus.alive_mask), 32'h7F7F_7F7F);
        for (int k = 1; k <= 47; k++) push(s + 30 * k, 40 + 4 * k, 40, 1, 0);
        push(s + 1441, 228, 56, 0, 1);
        mon_en = 1'b1;
        wait_until(s + 1442);
        chk("w2_sb_drained", 32'(sb.size()), 32'd0);
        mon_en = 1'b0;
        sb.delete();

        // Kill everything. The march step at s+1471 still commits (x=224).
        // The origin then freezes once the wave clears.
        wait_until(s + 1444);
        for (int i = 0; i < 32; i++) kill(i % 8, i / 8);
        chk("cleared_flag",  32'(bus.wave_cleared), 32'd1);
        chk("cleared_count", 32'(bus.alive_count), 32'd0);
        chk("cleared_mask",  32'(bus.alive_mask), 32'h0);
        chk("cleared_x",     32'(bus.fleet_x), 32'd224);
        repeat (60) tick();
        chk("cleared_frozen_x", 32'(bus.fleet_x), 32'd224);
        chk("cleared_frozen_y", 32'(bus.fleet_y), 32'd56);
        chk("cleared_held",     32'(bus.wave_cleared), 32'd1);

        pulse_start();
        chk("reload_wave_num", 32'(bus.wave_num), 32'd2);
        chk("reload_x",        32'(bus.fleet_x), 32'd40);
        chk("reload_y",        32'(bus.fleet_y), 32'd40);
        chk("reload_mask",     32'(bus.alive_mask), 32'hFFFF_FFFF);
        chk("reload_count",    32'(bus.alive_count), 32'd32);
        chk("reload_dir_x",    32'(bus.enemy_direction_X), 32'd1);
        chk("reload_cleared",  32'(bus.wave_cleared), 32'd0);
        repeat (45) tick();
        chk("reload_first_step_x", 32'(bus.fleet_x), 32'd44);

        // Reset in the middle of a march aborts the wave.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset();
        repeat (40) tick();
        chk("idle_after_reset_x", 32'(bus.fleet_x), 32'd40);

`ifdef FLEET_SPEEDUP_EN
        // Period 30 at a full count. After the population drops to 5, the
        // period becomes 7 from the next wrap.
        pulse_start();
        s = cyc;
        for (int i = 0; i < 27; i++) kill(i % 8, i / 8);
        chk("speedup_count", 32'(bus.alive_count), 32'd5);
        push(s + 30, 44, 40, 1, 0);
        push(s + 37, 48, 40, 1, 0);
        push(s + 44, 52, 40, 1, 0);
        mon_en = 1'b1;
        wait_until(s + 46);
        chk("speedup_sb_drained", 32'(sb.size()), 32'd0);
        mon_en = 1'b0;
        sb.delete();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

`default_nettype wire
